// File: rtl/params_proc.sv
// params_proc: widths, opcodes, field positions and state encodings shared by the processor pipeline stages.
package params_proc;
  localparam int INSTR_WIDTH = 32;
  localparam int PC_WIDTH = 16;
  localparam logic [5:0] OP_JMP = 6'h02;
  localparam logic [5:0] OP_BRA = 6'h03;
  localparam int OP_LSB = 26;
  localparam int RD_LSB = 21;
  localparam int RS_LSB = 16;
  localparam int RT_LSB = 11;
  localparam int IMM_LSB = 0;
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [15:0] imm;
  } fields_t;
  function automatic logic [PC_WIDTH-1:0] sext_imm(input logic [15:0] imm);
    return PC_WIDTH'(signed'(imm));
  endfunction
endpackage

// File: rtl/pipeline2_fields.sv
// pipeline2_fields: combinational field split, control-flow detection and redirect target.
// PIPELINE2_REL_BRANCH_EN enables PC-relative BRA; otherwise opcode 6'h03 is an ordinary instruction.
module pipeline2_fields
  import params_proc::*;
(
  input  logic [INSTR_WIDTH-1:0] instr,
`ifdef PIPELINE2_REL_BRANCH_EN
  input  logic [PC_WIDTH-1:0]    pc_f,
`endif
  output fields_t                f,
  output logic                   is_jump,
  output logic                   is_branch,
  output logic [PC_WIDTH-1:0]    target
);
  always_comb begin
    f.opcode = instr[OP_LSB +: 6];
    f.rd = instr[RD_LSB +: 5];
    f.rs = instr[RS_LSB +: 5];
    f.rt = instr[RT_LSB +: 5];
    f.imm = instr[IMM_LSB +: 16];
  end
  assign is_jump = f.opcode == OP_JMP;
`ifdef PIPELINE2_REL_BRANCH_EN
  assign is_branch = f.opcode == OP_BRA;
  assign target = is_branch ? pc_f + PC_WIDTH'(1) + sext_imm(f.imm) : instr[PC_WIDTH-1:0];
`else
  assign is_branch = 1'b0;
  assign target = instr[PC_WIDTH-1:0];
`endif
endmodule

// File: rtl/pipeline2.sv
// pipeline2: decode stage; splits fetch instructions, resolves JMP/BRA and replays refused instructions via pc_chg/pc_in.
// PIPELINE2_REL_BRANCH_EN enables PC-relative BRA redirects.
module pipeline2
  import params_proc::*;
(
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic [PC_WIDTH-1:0]    pc_f,
  input  logic                   done,
  input  logic                   stall_in,
  output logic                   pc_chg,
  output logic [PC_WIDTH-1:0]    pc_in,
  output logic                   valid_out,
  output logic [5:0]             opcode,
  output logic [4:0]             rd,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic [15:0]            imm,
  output logic [PC_WIDTH-1:0]    pc_out
);
  logic [0:0] state;
  logic [PC_WIDTH-1:0] exp_pc;
  fields_t dec, f_q;
  logic is_jump, is_branch;
  logic [PC_WIDTH-1:0] target;
  logic can_take, on_path, take, replay, redir;
  pipeline2_fields u_fields (
    .instr(instr),
`ifdef PIPELINE2_REL_BRANCH_EN
    .pc_f(pc_f),
`endif
    .f(dec),
    .is_jump(is_jump),
    .is_branch(is_branch),
    .target(target)
  );
  assign can_take = !valid_out || !stall_in;
  // In SQUASH only the awaited PC is on the correct path; everything else is wrong-path.
  assign on_path = done && (state == ST_RUN || pc_f == exp_pc);
  assign take = on_path && can_take;
  assign replay = on_path && !can_take;
  assign redir = take && (is_jump || is_branch);
  always_ff @(posedge clk_in or negedge RST) begin
    if (!RST) begin
      state <= ST_RUN;
      exp_pc <= '0;
      pc_chg <= 1'b0;
      pc_in <= '0;
      valid_out <= 1'b0;
      f_q <= '0;
      pc_out <= '0;
    end else begin
      pc_chg <= redir || replay;
      if (redir || replay) begin
        pc_in <= redir ? target : pc_f;
        exp_pc <= redir ? target : pc_f;
        state <= ST_SQUASH;
      end else if (take) state <= ST_RUN;
      if (take) begin
        f_q <= dec;
        pc_out <= pc_f;
        valid_out <= 1'b1;
      end else if (!stall_in) valid_out <= 1'b0;
    end
  end
  assign opcode = f_q.opcode;
  assign rd = f_q.rd;
  assign rs = f_q.rs;
  assign rt = f_q.rt;
  assign imm = f_q.imm;
endmodule
